// File: rtl/gmii_tx_arbiter.sv
// ============================================================================
// Module   : gmii_tx_arbiter
// Purpose  : Frame-granular round-robin arbiter that merges two byte-stream
//            sources onto one GMII transmit port. It enforces a minimum
//            inter-frame gap and marks underruns as GMII errors.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gmii_tx_arbiter #(
  parameter int IFG_BYTES = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  input  logic       req0_err,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  input  logic       req1_err,
  output logic       req1_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       gmii_txer,
  output logic       grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_IFG  = 2'd2
  } state_t;

  // The counter is loaded with one less than the gap because the SEND->IFG
  // edge itself accounts for the first idle cycle on the wire.
  localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] ifg_cnt_q, ifg_cnt_d;
  logic [7:0] txd_q, txd_d;
  logic       txen_q, txen_d;
  logic       txer_q, txer_d;

  logic       any_req;
  logic       winner;
  logic       g_valid;
  logic [7:0] g_data;
  logic       g_last;
  logic       g_err;

  // Request view and round-robin choice: on a tie the source that did not
  // win last time takes the channel.
  always_comb begin
    any_req = req0_valid | req1_valid;
    winner  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    g_valid = grant_q ? req1_valid : req0_valid;
    g_data  = grant_q ? req1_data  : req0_data;
    g_last  = grant_q ? req1_last  : req0_last;
    g_err   = grant_q ? req1_err   : req0_err;
  end

  // Next-state and registered-output logic; outputs idle unless sending.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ifg_cnt_d    = ifg_cnt_q;
    txd_d        = 8'h00;
    txen_d       = 1'b0;
    txer_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d      = S_SEND;
          grant_d      = winner;
          last_grant_d = winner;
        end
      end
      S_SEND: begin
        txen_d = 1'b1;
        if (g_valid) begin
          txd_d  = g_data;
          txer_d = g_err;
          if (g_last) begin
            state_d   = S_IFG;
            ifg_cnt_d = IFG_LOAD;
          end
        end else begin
          // Source starved mid-frame: keep the frame open but poison it.
          txer_d = 1'b1;
        end
      end
      S_IFG: begin
        if (ifg_cnt_q != 8'd0) begin
          ifg_cnt_d = ifg_cnt_q - 8'd1;
        end else if (any_req) begin
          state_d      = S_SEND;
          grant_d      = winner;
          last_grant_d = winner;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset makes source 0 win the first contest.
  always_ff @(posedge gmii_tx_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ifg_cnt_q    <= 8'd0;
      txd_q        <= 8'h00;
      txen_q       <= 1'b0;
      txer_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ifg_cnt_q    <= ifg_cnt_d;
      txd_q        <= txd_d;
      txen_q       <= txen_d;
      txer_q       <= txer_d;
    end
  end

  // Handshake and status are decoded straight from the state register.
  always_comb begin
    req0_ready = (state_q == S_SEND) && !grant_q;
    req1_ready = (state_q == S_SEND) &&  grant_q;
    busy       = (state_q != S_IDLE);
    grant      = grant_q;
    gmii_txd   = txd_q;
    gmii_txen  = txen_q;
    gmii_txer  = txer_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_gmii_tx_arbiter.sv
// ============================================================================
// Module   : tb_gmii_tx_arbiter
// Purpose  : Directed self-checking bench for gmii_tx_arbiter (default gap
//            instance plus a one-cycle-gap instance).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gmii_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  logic       req0_valid, req0_last, req0_err, req0_ready;
  logic       req1_valid, req1_last, req1_err, req1_ready;
  logic [7:0] req0_data, req1_data, gmii_txd;
  logic       gmii_txen, gmii_txer, grant, busy;

  logic       b_req0_valid, b_req0_last, b_req0_err, b_req0_ready;
  logic       b_req1_valid, b_req1_last, b_req1_err, b_req1_ready;
  logic [7:0] b_req0_data, b_req1_data, b_gmii_txd;
  logic       b_gmii_txen, b_gmii_txer, b_grant, b_busy;

  gmii_tx_arbiter dut (
    .gmii_tx_clk(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
    .req0_err(req0_err), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
    .req1_err(req1_err), .req1_ready(req1_ready),
    .gmii_txd(gmii_txd), .gmii_txen(gmii_txen), .gmii_txer(gmii_txer),
    .grant(grant), .busy(busy)
  );

  gmii_tx_arbiter #(.IFG_BYTES(1)) dut_b (
    .gmii_tx_clk(clk), .reset(rst),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_last(b_req0_last),
    .req0_err(b_req0_err), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_last(b_req1_last),
    .req1_err(b_req1_err), .req1_ready(b_req1_ready),
    .gmii_txd(b_gmii_txd), .gmii_txen(b_gmii_txen), .gmii_txer(b_gmii_txer),
    .grant(b_grant), .busy(b_busy)
  );

  typedef struct packed {
    logic       r0;
    logic       r1;
    logic       txen;
    logic       txer;
    logic [7:0] txd;
  } samp_t;

  samp_t log_a[$];
  samp_t log_b[$];
  bit    logging = 1'b0;

  // Per-cycle snapshot of both instances, taken mid-cycle.
  always @(negedge clk) begin
    if (logging) begin
      log_a.push_back('{req0_ready, req1_ready, gmii_txen, gmii_txer, gmii_txd});
      log_b.push_back('{b_req0_ready, b_req1_ready, b_gmii_txen, b_gmii_txer, b_gmii_txd});
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l, input logic e);
    case (src)
      0:       begin req0_valid = v; req0_data = d; req0_last = l; req0_err = e; end
      1:       begin req1_valid = v; req1_data = d; req1_last = l; req1_err = e; end
      default: begin b_req0_valid = v; b_req0_data = d; b_req0_last = l; b_req0_err = e; end
    endcase
  endtask

  function automatic logic ready_of(input int src);
    case (src)
      0:       return req0_ready;
      1:       return req1_ready;
      default: return b_req0_ready;
    endcase
  endfunction

  // Present a frame (byte i at d[8*i +: 8]); valid is dropped for gap_len
  // cycles before byte gap_at. Valid is left asserted afterwards so a
  // following call can present the next frame back to back.
  task automatic send(input int src, input logic [63:0] d, input int n,
                      input logic [7:0] errmask, input int gap_at, input int gap_len);
    int i  = 0;
    int bg = 0;
    int gl = gap_len;
    while (i < n && bg < 100) begin
      @(negedge clk);
      bg++;
      if (i == gap_at && gl > 0) begin
        drive(src, 1'b0, 8'h00, 1'b0, 1'b0);
        gl--;
      end else begin
        drive(src, 1'b1, d[8*i +: 8], (i == n - 1), errmask[i]);
        if (ready_of(src)) i++;
      end
    end
    check_eq($sformatf("send%0d_done", src), i, n);
  endtask

  task automatic idle(input int src);
    @(negedge clk);
    drive(src, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic int first_txen(input samp_t q[$], input int from);
    for (int i = from; i < q.size(); i++)
      if (q[i].txen) return i;
    return -1;
  endfunction

  function automatic int count_idle(input samp_t q[$], input int from);
    int c = 0;
    for (int i = from; i < q.size(); i++) begin
      if (q[i].txen) return c;
      c++;
    end
    return c;
  endfunction

  task automatic expect_seq(input string tag, input samp_t q[$], input int at,
                            input logic [63:0] d, input logic [7:0] er, input int n);
    samp_t s;
    for (int i = 0; i < n; i++) begin
      s = (at >= 0 && at + i < q.size()) ? q[at + i] : '0;
      check_eq($sformatf("%s_b%0d", tag, i), {s.txen, s.txer, s.txd}, {1'b1, er[i], d[8*i +: 8]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int g;
    logic [5:0] pat;
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0);
    drive(2, 0, 8'h00, 0, 0);
    b_req1_valid = 1'b0; b_req1_data = 8'h00; b_req1_last = 1'b0; b_req1_err = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_outs", {gmii_txd, gmii_txen, gmii_txer, req0_ready, req1_ready, grant, busy}, 0);
    check_eq("rst_outs_b", {b_gmii_txd, b_gmii_txen, b_gmii_txer, b_req0_ready, b_req1_ready, b_grant, b_busy}, 0);
    rst = 1'b0;

    // Single source 0 frame, latency and content
    @(posedge clk);
    log_a.delete(); log_b.delete(); logging = 1'b1;
    send(0, 64'h01_AA_D5_55, 4, 8'h00, -1, 0);
    idle(0);
    repeat (16) @(negedge clk);
    @(posedge clk) logging = 1'b0;
    f = first_txen(log_a, 0);
    check_eq("t1_latency", f, 2);
    check_eq("t1_ready_early", (log_a.size() > 1) ? log_a[1].r0 : 1'b0, 1'b1);
    expect_seq("t1", log_a, f, 64'h01_AA_D5_55, 8'h00, 4);
    check_eq("t1_tail_idle", count_idle(log_a, f + 4), log_a.size() - (f + 4));

    // Both sources from reset release: round robin with full gap
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    log_a.delete(); log_b.delete(); logging = 1'b1;
    fork
      begin send(0, 64'h12_11_10, 3, 8'h00, -1, 0); send(0, 64'h32_31_30, 3, 8'h00, -1, 0); idle(0); end
      begin send(1, 64'h22_21_20, 3, 8'h00, -1, 0); idle(1); end
    join
    repeat (4) @(negedge clk);
    @(posedge clk) logging = 1'b0;
    f = first_txen(log_a, 0);
    expect_seq("t2_src0", log_a, f, 64'h12_11_10, 8'h00, 3);
    check_eq("t2_gap1", count_idle(log_a, f + 3), 12);
    expect_seq("t2_src1", log_a, f + 15, 64'h22_21_20, 8'h00, 3);
    check_eq("t2_gap2", count_idle(log_a, f + 18), 12);
    expect_seq("t2_third", log_a, f + 30, 64'h32_31_30, 8'h00, 3);
    repeat (16) @(negedge clk);

    // Source 1 underrun mid-frame while source 0 waits
    @(posedge clk);
    log_a.delete(); log_b.delete(); logging = 1'b1;
    fork
      begin send(1, 64'h24_23_22_21_20, 5, 8'h00, 2, 2); idle(1); end
      begin repeat (3) @(negedge clk); send(0, 64'h41_40, 2, 8'h00, -1, 0); idle(0); end
    join
    repeat (4) @(negedge clk);
    @(posedge clk) logging = 1'b0;
    f = first_txen(log_a, 0);
    expect_seq("t3_underrun", log_a, f, 64'h24_23_22_00_00_21_20, 8'b0000_1100, 7);
    g = 0;
    for (int i = 0; i <= f + 6 && i < log_a.size(); i++) g += int'(log_a[i].r0);
    check_eq("t3_ready0_low", g, 0);
    check_eq("t3_gap", count_idle(log_a, f + 7), 12);
    expect_seq("t3_src0", log_a, f + 19, 64'h41_40, 8'h00, 2);
    repeat (16) @(negedge clk);

    // Error mark on byte 3 of 5
    @(posedge clk);
    log_a.delete(); log_b.delete(); logging = 1'b1;
    send(0, 64'h55_44_33_22_11, 5, 8'b0000_0100, -1, 0);
    idle(0);
    repeat (3) @(negedge clk);
    @(posedge clk) logging = 1'b0;
    f = first_txen(log_a, 0);
    expect_seq("t4_err", log_a, f, 64'h55_44_33_22_11, 8'b0000_0100, 5);
    repeat (16) @(negedge clk);

    // Asynchronous reset mid-frame, then source 1 granted without a gap
    @(negedge clk) drive(0, 1, 8'hA0, 0, 0);
    @(negedge clk);
    check_eq("t5_ready0", req0_ready, 1'b1);
    drive(1, 1, 8'h77, 1, 0);
    @(negedge clk);
    check_eq("t5_byte1", {gmii_txen, gmii_txd}, {1'b1, 8'hA0});
    drive(0, 1, 8'hA1, 0, 0);
    @(negedge clk);
    check_eq("t5_byte2", {gmii_txen, gmii_txd}, {1'b1, 8'hA1});
    #1 rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0);
    #1 check_eq("t5_async_rst", {gmii_txd, gmii_txen, gmii_txer, req0_ready, req1_ready, grant, busy}, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_eq("t5_grant1", {grant, req1_ready, req0_ready, busy, gmii_txen}, 5'b11010);
    @(negedge clk);
    check_eq("t5_no_gap", {gmii_txen, gmii_txer, gmii_txd}, {2'b10, 8'h77});
    drive(1, 0, 8'h00, 0, 0);
    @(negedge clk);
    check_eq("t5_ifg", {gmii_txen, busy}, 2'b01);
    repeat (16) @(negedge clk);

    // One-cycle gap instance, back-to-back frames from source 0
    @(posedge clk);
    log_a.delete(); log_b.delete(); logging = 1'b1;
    send(2, 64'hB1_B0, 2, 8'h00, -1, 0);
    send(2, 64'hC1_C0, 2, 8'h00, -1, 0);
    idle(2);
    repeat (4) @(negedge clk);
    @(posedge clk) logging = 1'b0;
    f = first_txen(log_b, 0);
    pat = '0;
    for (int k = 0; k < 6; k++)
      pat[5-k] = (f >= 0 && f + k < log_b.size()) ? log_b[f + k].txen : 1'b0;
    check_eq("t6_txen_pattern", pat, 6'b110110);
    expect_seq("t6_f1", log_b, f, 64'hB1_B0, 8'h00, 2);
    expect_seq("t6_f2", log_b, f + 3, 64'hC1_C0, 8'h00, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
